dem_pn_generator: RTL

//  Upstream stage of the DEM-DAC switching tree. Produces one pseudo-random bit
//  per switching block per DAC sample; each bit drives that block's pn_seq_i.
//  One independent 15-bit Fibonacci LFSR per lane, with runtime seed load,

---
 rtl/dem_pkg.sv | 39 +++
 rtl/dem_pn_generator_if.sv | 25 ++
 rtl/dem_lfsr_lane.sv | 55 +++++
 rtl/dem_pn_generator.sv | 85 ++++++++
 4 files changed

// File: rtl/dem_pkg.sv
// Shared constants and types for the DEM pseudo-random bit generator:
// LFSR geometry, per-lane default seeds and the seed-write request bundle.
package dem_pkg;

  localparam int DEM_LFSR_LEN = 15;
  localparam int DEM_NUM_SB   = 7;
  localparam int DEM_IDX_W    = ($clog2(DEM_NUM_SB) > 0) ? $clog2(DEM_NUM_SB) : 1;

  typedef logic [DEM_LFSR_LEN-1:0] lfsr_t;
  typedef logic [DEM_IDX_W-1:0]    lane_idx_t;

  // x^15 + x^14 + 1: feedback from the two most significant stages
  localparam int DEM_TAP_HI = DEM_LFSR_LEN - 1;
  localparam int DEM_TAP_LO = DEM_LFSR_LEN - 2;

  // Last count value before the period marker wraps the counter to zero.
  localparam lfsr_t DEM_CNT_LAST = lfsr_t'((2 ** DEM_LFSR_LEN) - 2);

  localparam lfsr_t DEM_DEFAULT_SEED [DEM_NUM_SB] = '{
    15'h4000,
    15'h1234,
    15'h5A5A,
    15'h0F0F,
    15'h7ACE,
    15'h3C3C,
    15'h6001
  };

  typedef struct packed {
    logic      we;
    lane_idx_t idx;
    lfsr_t     val;
  } seed_req_t;

  function automatic logic lfsr_fb(input lfsr_t state);
    return state[DEM_TAP_HI] ^ state[DEM_TAP_LO];
  endfunction

endpackage

// File: rtl/dem_pn_generator_if.sv
// Control/status bundle between the DEM sequencer and the PN generator.
interface dem_pn_generator_if;
  import dem_pkg::*;

  logic                  step_i;
  logic                  dem_en_i;
  logic                  seed_we_i;
  lane_idx_t             seed_idx_i;
  lfsr_t                 seed_i;
  logic [DEM_NUM_SB-1:0] pn_o;
  logic                  wrap_o;
  logic                  seed_err_o;
  logic                  lockup_o;

  modport master (
    output step_i, dem_en_i, seed_we_i, seed_idx_i, seed_i,
    input  pn_o, wrap_o, seed_err_o, lockup_o
  );

  modport slave (
    input  step_i, dem_en_i, seed_we_i, seed_idx_i, seed_i,
    output pn_o, wrap_o, seed_err_o, lockup_o
  );

endinterface

// File: rtl/dem_lfsr_lane.sv
// One DEM lane: 15-bit Fibonacci LFSR with seed load, registered PN bit
// and all-zero lock-up recovery back to the lane's default seed.
module dem_lfsr_lane
  import dem_pkg::*;
#(
  parameter lfsr_t DEFAULT_SEED = 15'h0001
) (
  input  logic  clk_i,
  input  logic  reset_i,
  input  logic  step_i,
  input  logic  dem_en_i,
  input  logic  load_i,
  input  lfsr_t load_val_i,
  output logic  pn_o,
  output logic  lock_det_o
);

  lfsr_t lfsr_q, lfsr_d;
  logic  pn_q, pn_d;
  logic  fb;

  assign fb = lfsr_fb(lfsr_q);

  always_comb begin
    lfsr_d     = lfsr_q;
    pn_d       = pn_q;
    lock_det_o = 1'b0;
    // A seed write wins over a step: the lane is re-seeded and its PN bit holds.
    if (load_i) begin
      lfsr_d = (load_val_i == '0) ? DEFAULT_SEED : load_val_i;
    end else if (step_i) begin
      if (lfsr_q == '0) begin
        lfsr_d     = DEFAULT_SEED;
        pn_d       = 1'b0;
        lock_det_o = 1'b1;
      end else begin
        lfsr_d = {lfsr_q[DEM_LFSR_LEN-2:0], fb};
        pn_d   = dem_en_i & fb;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lfsr_q <= DEFAULT_SEED;
      pn_q   <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      pn_q   <= pn_d;
    end
  end

  assign pn_o = pn_q;

endmodule

// File: rtl/dem_pn_generator.sv
// DEM PN generator: one LFSR lane per switching block, seed-write decode,
// period counter with wrap marker, and seed-error / lock-up status flags.
module dem_pn_generator
  import dem_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_i,
  dem_pn_generator_if.slave  bus
);

  localparam int NUM_SB = DEM_NUM_SB;

  seed_req_t            req;
  logic                 idx_ok;
  logic                 seed_hit;
  logic [NUM_SB-1:0]    load;
  logic [NUM_SB-1:0]    pn_vec;
  logic [NUM_SB-1:0]    lock_det;

  lfsr_t cnt_q, cnt_d;
  logic  wrap_q, wrap_d;
  logic  seed_err_q, seed_err_d;
  logic  lockup_q, lockup_d;

  assign req = '{we: bus.seed_we_i, idx: bus.seed_idx_i, val: bus.seed_i};

  // Extra MSB keeps the range check correct if NUM_SB is ever a power of two.
  assign idx_ok   = {1'b0, req.idx} < (DEM_IDX_W + 1)'(NUM_SB);
  assign seed_hit = req.we & idx_ok;

  for (genvar k = 0; k < NUM_SB; k++) begin : g_lane
    assign load[k] = seed_hit & (req.idx == lane_idx_t'(k));

    dem_lfsr_lane #(
      .DEFAULT_SEED (DEM_DEFAULT_SEED[k])
    ) u_lane (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .step_i     (bus.step_i),
      .dem_en_i   (bus.dem_en_i),
      .load_i     (load[k]),
      .load_val_i (req.val),
      .pn_o       (pn_vec[k]),
      .lock_det_o (lock_det[k])
    );
  end

  always_comb begin
    cnt_d      = cnt_q;
    wrap_d     = 1'b0;
    seed_err_d = req.we & (~idx_ok | (req.val == '0));
    lockup_d   = lockup_q | (|lock_det);
    // Any accepted or substituted seed restarts the period count.
    if (seed_hit) begin
      cnt_d = '0;
    end else if (bus.step_i) begin
      if (cnt_q == DEM_CNT_LAST) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
      end else begin
        cnt_d = cnt_q + lfsr_t'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q      <= '0;
      wrap_q     <= 1'b0;
      seed_err_q <= 1'b0;
      lockup_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wrap_q     <= wrap_d;
      seed_err_q <= seed_err_d;
      lockup_q   <= lockup_d;
    end
  end

  assign bus.pn_o       = pn_vec;
  assign bus.wrap_o     = wrap_q;
  assign bus.seed_err_o = seed_err_q;
  assign bus.lockup_o   = lockup_q;

endmodule
